// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port unified instruction/data memory between the fetch
// stage and the MEM stage. Each access is serialised: a one-cycle command,
// MEM_LAT cycles of read latency, then a one-cycle completion pulse. The data
// side has strict priority over fetch. Stall outputs freeze the pipeline while
// a request is outstanding.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   if_req/if_addr               fetch request, held until if_valid
//   if_rdata/if_valid            registered fetch word + one-cycle pulse
//   dm_read/dm_write/dm_addr/dm_wdata  load/store request from MEM stage
//   dm_rdata/dm_done             registered load data + one-cycle pulse
//   stall_if/stall_mem           pipeline freeze controls (combinational)
//   busy                         high while an access is in flight (BUSY/RESP)
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata                    memory read data, valid MEM_LAT cycles after mem_en
module unified_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             owner_dm;   // 1: data side owns the current access
  logic             write_flag; // current access is a store
  logic [CNT_W-1:0] cnt;
  logic             dm_any;
  logic             grant;
  logic             capture;

  assign dm_any = dm_read | dm_write;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; requests are only looked at in IDLE, so the requester
  // still presenting its completed request during RESP is not re-granted.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (dm_any || if_req) begin
          grant      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: command, latency counter, read capture and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_dm   <= 1'b0;
      write_flag <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_done    <= 1'b0;
    end else begin
      mem_en   <= grant;
      mem_we   <= grant & dm_write;
      if_valid <= capture & ~owner_dm;
      dm_done  <= capture & owner_dm;

      if (grant) begin
        owner_dm   <= dm_any;
        // A simultaneous read+write is treated as a store.
        write_flag <= dm_write;
        cnt        <= CNT_W'(MEM_LAT);
        if (dm_any) begin
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_addr  <= if_addr;
        end
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (capture) begin
        if (!owner_dm) begin
          if_rdata <= mem_rdata;
        end else if (!write_flag) begin
          dm_rdata <= mem_rdata;
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign stall_mem = dm_any & ~dm_done;
  assign stall_if  = (if_req & ~if_valid) | stall_mem;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              stall_if;
  logic              stall_mem;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: writes on the command edge, read data valid MEM_LAT cycles
  // after the command cycle.
  logic [DATA_W-1:0] mem [0:255];
  logic [DATA_W-1:0] rd_pipe [0:MEM_LAT-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rd_pipe[0] <= mem[mem_addr];
    for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string             name;
    logic              is_dm;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              exp_we;
    logic [DATA_W-1:0] exp_data; // expected if_rdata or dm_rdata after the pulse
  } vec_t;

  vec_t vecs [7];

  // One full access: request presented in cycle r (current), checks through r+5.
  task automatic run_access(input vec_t v);
    logic [DATA_W-1:0] exp_wd;
    exp_wd = v.wr ? v.wdata : mem_wdata; // mem_wdata holds last value for reads
    if (v.is_dm) begin
      dm_read = v.rd; dm_write = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    check({v.name, " stall_if r"}, {31'd0, stall_if}, 32'd1);
    check({v.name, " stall_mem r"}, {31'd0, stall_mem}, {31'd0, v.is_dm});
    tick(); // r+1
    check({v.name, " mem_en r+1"}, {31'd0, mem_en}, 32'd1);
    check({v.name, " mem_we"}, {31'd0, mem_we}, {31'd0, v.exp_we});
    check({v.name, " mem_addr"}, {24'd0, mem_addr}, {24'd0, v.addr});
    if (v.exp_we) check({v.name, " mem_wdata"}, {16'd0, mem_wdata}, {16'd0, exp_wd});
    check({v.name, " busy r+1"}, {31'd0, busy}, 32'd1);
    tick(); // r+2
    check({v.name, " mem_en r+2"}, {31'd0, mem_en}, 32'd0);
    tick(); // r+3
    check({v.name, " pulse early"}, {30'd0, if_valid, dm_done}, 32'd0);
    tick(); // r+4
    check({v.name, " if_valid r+4"}, {31'd0, if_valid}, {31'd0, ~v.is_dm});
    check({v.name, " dm_done r+4"}, {31'd0, dm_done}, {31'd0, v.is_dm});
    if (v.is_dm) check({v.name, " dm_rdata"}, {16'd0, dm_rdata}, {16'd0, v.exp_data});
    else         check({v.name, " if_rdata"}, {16'd0, if_rdata}, {16'd0, v.exp_data});
    check({v.name, " stall_if r+4"}, {31'd0, stall_if}, 32'd0);
    check({v.name, " busy r+4"}, {31'd0, busy}, 32'd1);
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
    tick(); // r+5
    check({v.name, " pulse r+5"}, {30'd0, if_valid, dm_done}, 32'd0);
    check({v.name, " busy r+5"}, {31'd0, busy}, 32'd0);
    check({v.name, " mem_en r+5"}, {31'd0, mem_en}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h05] = 16'h0505;
    mem[8'h10] = 16'hA5A5;
    mem[8'h20] = 16'hBEEF;
    mem[8'h33] = 16'hC0DE;
    for (int k = 0; k < MEM_LAT; k++) rd_pipe[k] = '0;

    //          name        dm   rd   wr   addr   wdata     we   exp_data
    vecs[0] = '{"fetch10", 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, 16'hA5A5};
    vecs[1] = '{"load20",  1'b1, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 16'hBEEF};
    vecs[2] = '{"store21", 1'b1, 1'b0, 1'b1, 8'h21, 16'h1234, 1'b1, 16'hBEEF};
    vecs[3] = '{"load21",  1'b1, 1'b1, 1'b0, 8'h21, 16'h0000, 1'b0, 16'h1234};
    vecs[4] = '{"fetch33", 1'b0, 1'b0, 1'b0, 8'h33, 16'h0000, 1'b0, 16'hC0DE};
    vecs[5] = '{"rdwr22",  1'b1, 1'b1, 1'b1, 8'h22, 16'h7777, 1'b1, 16'h1234};
    vecs[6] = '{"load22",  1'b1, 1'b1, 1'b0, 8'h22, 16'h0000, 1'b0, 16'h7777};

    rst = 1'b1; if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0; dm_addr = 0; dm_wdata = 0;
    tick(); tick();
    check("reset outs", {24'd0, mem_en, mem_we, if_valid, dm_done, busy, stall_if, stall_mem, 1'b0}, 32'd0);
    check("reset data", {if_rdata, dm_rdata}, 32'd0);
    check("reset mem_addr", {24'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_access(vecs[i]);

    // Contention: fetch and load together; data side first, no grant in RESP.
    if_req = 1; if_addr = 8'h10; dm_read = 1; dm_addr = 8'h20;
    tick(); // r+1
    check("cont mem_addr dm", {24'd0, mem_addr}, 32'h20);
    tick(); tick(); tick(); // r+4
    check("cont dm_done", {31'd0, dm_done}, 32'd1);
    check("cont if_valid r+4", {31'd0, if_valid}, 32'd0);
    check("cont dm_rdata", {16'd0, dm_rdata}, 32'hBEEF);
    check("cont stall_mem r+4", {31'd0, stall_mem}, 32'd0);
    dm_read = 0;
    tick(); // r+5
    check("cont mem_en r+5", {31'd0, mem_en}, 32'd0);
    check("cont stall_if r+5", {31'd0, stall_if}, 32'd1);
    tick(); // r+6
    check("cont mem_en r+6", {31'd0, mem_en}, 32'd1);
    check("cont mem_addr if", {24'd0, mem_addr}, 32'h10);
    tick(); tick(); // r+8
    check("cont if_valid r+8", {31'd0, if_valid}, 32'd0);
    tick(); // r+9
    check("cont if_valid r+9", {31'd0, if_valid}, 32'd1);
    check("cont if_rdata", {16'd0, if_rdata}, 32'hA5A5);
    if_req = 0;
    tick();
    check("cont idle", {30'd0, busy, mem_en}, 32'd0);

    // Withdrawal mid-BUSY: load still completes.
    dm_read = 1; dm_addr = 8'h33;
    tick(); tick(); // r+2
    dm_read = 0;
    tick(); tick(); // r+4
    check("wd dm_done", {31'd0, dm_done}, 32'd1);
    check("wd dm_rdata", {16'd0, dm_rdata}, 32'hC0DE);
    tick();

    // Reset during BUSY: immediate clear, no pulse afterwards.
    if_req = 1; if_addr = 8'h33;
    tick(); tick(); // r+2 (BUSY)
    if_req = 0;
    #2 rst = 1'b1;
    #1;
    check("arst outs", {26'd0, mem_en, mem_we, if_valid, dm_done, busy, 1'b0}, 32'd0);
    check("arst data", {if_rdata, dm_rdata}, 32'd0);
    check("arst addr/wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst no pulse", {29'd0, if_valid, dm_done, busy}, 32'd0);
    end
    if_req = 1; if_addr = 8'h05;
    tick(); // r+1
    check("post-rst mem_en", {31'd0, mem_en}, 32'd1);
    check("post-rst mem_addr", {24'd0, mem_addr}, 32'h05);
    tick(); tick(); tick(); // r+4
    check("post-rst if_valid", {31'd0, if_valid}, 32'd1);
    check("post-rst if_rdata", {16'd0, if_rdata}, 32'h0505);
    if_req = 0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequential arbiter sharing one single-port unified instruction/data memory between the pipeline's fetch stage and the MEM stage (LW/SW). It serialises accesses, drives the memory command with fixed read latency, returns fetch words and load data, and generates the stall signals that freeze the pipeline while an access is outstanding. It sits between the IF/MEM stages and the memory, alongside the main control unit whose mem_read/mem_write outputs feed its data-side request.

## Interface
- ADDR_W, 8, memory word-address width
- DATA_W, 16, data/instruction word width
- MEM_LAT, 2, cycles from memory command to read data valid (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset: one clock; reset is asynchronous and active-high
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  fetched instruction, registered
- if_valid  out  1  one-cycle fetch completion pulse
- dm_read  in  1  load request (control mem_read via pipeline)
- dm_write  in  1  store request (control mem_write via pipeline)
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_done  out  1  one-cycle data-access completion pulse
- stall_if  out  1  freeze PC and IF/ID
- stall_mem  out  1  freeze whole pipeline
- busy  out  1  high in BUSY and RESP
- mem_en, mem_we  out  1 each  memory command strobe / write enable
- mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, BUSY, RESP. Registers: state, owner (IF/DM), write flag, latency counter (width clog2(MEM_LAT+1)).
- IDLE: at clock edge, if dm_read|dm_write → owner=DM; else if if_req → owner=IF; else stay. Data side has strict priority (older instruction). No starvation: a data request cannot recur without pipeline advance, which requires the fetch.
- On grant: next cycle is BUSY; mem_en=1 for that single cycle with mem_addr, mem_we (=dm_write for DM, 0 for IF), mem_wdata latched from the granted requester; counter loaded with MEM_LAT.
- BUSY: counter decrements each cycle after the command cycle; at the cycle counter reaches 0, mem_rdata is valid and captured (into if_rdata or dm_rdata per owner; stores capture nothing) → RESP.
- RESP: if_valid or dm_done pulses one cycle; all requests ignored this cycle (requester still presents the completed request) → IDLE.
- dm_read & dm_write together: treated as a store; dm_rdata unchanged.
- Requester dropping its request during BUSY: access still completes, pulse still issued.
- stall_mem = (dm_read|dm_write) & ~dm_done (combinational).
- stall_if = (if_req & ~if_valid) | stall_mem.
- mem_en/mem_we/mem_addr/mem_wdata, if_rdata, dm_rdata, if_valid, dm_done registered; mem_addr/mem_wdata hold last value outside command cycle.

## Timing
- Reset (async, immediate): state=IDLE; mem_en, mem_we, if_valid, dm_done, busy = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0. Reset mid-access abandons it; no pulse issued.
- Request sampled at end of IDLE cycle r: mem_en in r+1; mem_rdata valid in r+1+MEM_LAT; pulse in r+2+MEM_LAT; IDLE in r+3+MEM_LAT.
- Per-access occupancy MEM_LAT+3 cycles; identical for loads, stores and fetches.
- Back-to-back: DM then IF pending together → DM pulse at r+4, IF sampled end of r+5, IF pulse at r+9 (MEM_LAT=2).

## Test plan
- Reset during BUSY (MEM_LAT=2): all outputs 0 immediately, no pulse; next if_req at addr 0x05 → mem_en 1 cycle later, if_valid 4 cycles after sample with if_rdata=mem[0x05].
- Fetch only: if_req addr 0x10, memory returns 0xA5A5 → mem_en in r+1, if_valid one cycle at r+4, if_rdata=0xA5A5, stall_if high r..r+3, low at r+4.
- Load: dm_read addr 0x20 → dm_done at r+4, dm_rdata=mem[0x20], stall_mem and stall_if high r..r+3.
- Store: dm_write addr 0x21 data 0x1234 → mem_en&mem_we one cycle, mem_wdata=0x1234, dm_done at r+4, dm_rdata unchanged.
- Contention: if_req and dm_read asserted same cycle → DM served first (pulse r+4), IF pulse r+9, no request sampled in either RESP cycle.
- dm_read&dm_write both high → single write issued, mem_we=1; request withdrawn mid-BUSY → dm_done still pulses at r+4.
